mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- CPU-side memory controller between the core's two memory requesters (instruction fetch, load/store unit) and the single byte-wide memory bus (mem_a/mem_dout/mem_wr/mem_din).
- Arbitrates the two requesters.
- Splits 1/2/4-byte accesses into byte cycles and assembles little-endian results.
- Honours rdy_in pause and io_buffer_full back-pressure for the I/O region.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- RAM_ADDR_WIDTH, 17, I/O region is addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11.

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  0 = bus borrowed by host; controller pauses.
- clear_in  input  1  pipeline flush; aborts outstanding reads.
- io_buffer_full  input  1  I/O output buffer full.
- if_req  input  1  fetch request, held until if_done.
- if_addr  input  32  fetch address, always 4 bytes.
- if_done  output  1  one-cycle pulse, if_data valid.
- if_data  output  32  fetched word.
- ls_req  input  1  load/store request, held until ls_done.
- ls_we  input  1  1 = store.
- ls_size  input  2  00 byte, 01 half, 10/11 word.
- ls_addr  input  32  access address.
- ls_wdata  input  32  store data, low bytes used.
- ls_done  output  1  one-cycle pulse.
- ls_rdata  output  32  load data, zero-extended.
- mem_din  input  8  read byte; returns the cycle after its address.
- mem_dout  output  8  write byte.
- mem_a  output  32  byte address.
- mem_wr  output  1  1 = write.

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE; last_grant = IF (so LSU wins first contention).
- States:
  - IDLE: accept a request.
  - IF_RD / LS_RD: issue N byte reads.
  - LS_WR: issue N byte writes.
  - DONE: one cycle, pulse the done output.
- Arbitration in IDLE:
  - Single requester: granted.
  - Both pending: the one not granted last time wins (alternating).
  - Grant latches the address, size, we and wdata.
- Read timing (cycle 0 = request sampled in IDLE):
  - Cycles 1..N: mem_a = A+i, mem_wr = 0.
  - Byte i is captured from mem_din in cycle i+2 into result byte i.
  - Cycle N+2: done = 1 with data valid; state returns to IDLE.
  - Examples: 4-byte fetch done in cycle 6; 1-byte load done in cycle 3.
- Write timing:
  - Cycles 1..N: mem_wr = 1, mem_a = A+i, mem_dout = wdata byte i.
  - Cycle N+1: ls_done = 1.
- Between requests:
  - A new request may be sampled in the DONE cycle; its first address appears the following cycle.
  - When not issuing, mem_wr = 0 and mem_a holds its last value.
- rdy_in = 0:
  - No state advance; mem_wr forced 0.
  - The issue index rolls back to the capture index.
  - Any byte issued in the cycle before or while rdy_in = 0 is reissued once rdy_in returns to 1; data from it is never captured.
- io_buffer_full = 1 during LS_WR to the I/O region:
  - The byte is not issued; mem_wr = 0 and the index holds.
  - Issue resumes the cycle after io_buffer_full drops.
- I/O reads: only requested bytes are issued; no speculative reads to the I/O region.
- clear_in = 1:
  - In IF_RD or LS_RD: abort to IDLE next cycle; no done pulse; partial data discarded.
  - LS_WR always completes.
  - A request present with clear_in in IDLE is not granted that cycle.
- Reset mid-operation: immediate return to IDLE; mem_wr drops the next cycle; no done pulse.
- ls_rdata upper bytes beyond size are 0; sign extension is the LSU's job.
- Address increment wraps modulo 2^32.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - state enum (IDLE, IF_RD, LS_RD, LS_WR, DONE);
  - size codes;
  - IO region tag 2'b11;
  - byte-count function from ls_size.
- One natural sub-module: mem_ctrl_arb, a two-way arbiter with a last_grant register.

Test Plan:
- if_req, if_addr=0x100, mem bytes 0x13,0x05,0x00,0x00 → mem_a 0x100..0x103 in cycles 1-4; if_done in cycle 6; if_data=0x00000513.
- ls_req store word 0xDEADBEEF at 0x2000 → mem_wr=1 cycles 1-4 with mem_dout EF,BE,AD,DE; ls_done in cycle 5.
- if_req and ls_req together, repeated → grants alternate LS, IF, LS, ...; neither starves.
- Byte store 0x41 to 0x30000 with io_buffer_full high for 3 cycles → no mem_wr for 3 cycles, then one write; ls_done one cycle later.
- rdy_in low for 2 cycles during a 4-byte fetch after byte 1 issued → byte 1 reissued; if_data correct; done delayed by exactly 3 cycles.
- clear_in in cycle 3 of a fetch → no if_done; next ls_req is granted in the following IDLE cycle.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types, codes and helpers for the memory controller
// Contents:
//   state_e     controller state encoding
//   SIZE_*      load/store size codes as presented on ls_size
//   IO_TAG      value of the two region bits that marks the I/O region
//   byte_count  number of byte cycles for a given ls_size code
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_IF_RD,
      ST_LS_RD,
      ST_LS_WR,
      ST_DONE
   } state_e;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [1:0] IO_TAG = 2'b11;

   // Code 2'b11 is treated as a word access as well.
   function automatic logic [2:0] byte_count(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 3'd1;
         SIZE_HALF: return 3'd2;
         SIZE_WORD: return 3'd4;
         default:   return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// rtl/mem_ctrl_arb.sv - two-way fetch/load-store arbiter with alternating priority
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset; last grant returns to fetch
//   en_i       a grant is being taken this cycle; updates the history
//   if_req_i   fetch requester pending
//   ls_req_i   load/store requester pending
//   gnt_vld_o  some requester can be granted
//   gnt_ls_o   1 = load/store wins, 0 = fetch wins (valid with gnt_vld_o)
module mem_ctrl_arb (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic if_req_i,
   input  logic ls_req_i,
   output logic gnt_vld_o,
   output logic gnt_ls_o
);

   // 1 = load/store received the previous grant. Resetting to fetch
   // lets the load/store unit win the first contention.
   logic last_ls_q;

   always_comb begin
      gnt_vld_o = if_req_i | ls_req_i;
      // Under contention the side that did not win last time gets it.
      gnt_ls_o  = ls_req_i & (~if_req_i | ~last_ls_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_ls_q <= 1'b0;
      end else if (en_i && gnt_vld_o) begin
         last_ls_q <= gnt_ls_o;
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - fetch/LSU to byte-wide memory bus controller
// Ports:
//   clk_in, rst_in        clock (rising edge), synchronous active-high reset
//   rdy_in                0 = bus lent to the host; controller pauses
//   clear_in              pipeline flush; aborts outstanding reads
//   io_buffer_full        I/O output buffer full; holds I/O-region writes
//   if_req/if_addr        fetch request (always 4 bytes), held until if_done
//   if_done/if_data       one-cycle completion pulse and fetched word
//   ls_req/ls_we/ls_size  load/store request, direction, size code
//   ls_addr/ls_wdata      access address and store data (low bytes used)
//   ls_done/ls_rdata      one-cycle completion pulse and zero-extended load data
//   mem_din               read byte, valid the cycle after its address
//   mem_dout/mem_a/mem_wr write byte, byte address, write strobe
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int RAM_ADDR_WIDTH = 17
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  clear_in,
   input  logic                  io_buffer_full,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_done,
   output logic [31:0]           if_data,
   input  logic                  ls_req,
   input  logic                  ls_we,
   input  logic [1:0]            ls_size,
   input  logic [ADDR_WIDTH-1:0] ls_addr,
   input  logic [31:0]           ls_wdata,
   output logic                  ls_done,
   output logic [31:0]           ls_rdata,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_wr
);

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH-1:0] mem_a_q;
   logic [2:0]            n_q;        // bytes in the access
   logic [2:0]            iss_q;      // reads: next byte to put on the bus; writes: byte on the bus
   logic [2:0]            cap_q;      // reads: bytes captured so far
   logic                  bus_act_q;  // a read address is on the bus this cycle
   logic                  din_vld_q;  // mem_din carries the byte for cap_q this cycle
   logic                  mem_wr_q;
   logic [7:0]            mem_dout_q;
   logic [31:0]           wdata_q;
   logic [31:0]           buf_q;
   logic                  if_done_q;
   logic                  ls_done_q;
   logic [31:0]           if_data_q;
   logic [31:0]           ls_rdata_q;

   logic                  gnt_vld;
   logic                  gnt_ls;
   logic                  grant_en;
   logic [ADDR_WIDTH-1:0] gnt_addr;
   logic                  cur_io;
   logic                  wr_fire;
   logic                  rd_cap;
   logic [2:0]            cap_d;
   logic [2:0]            nxt_idx;
   logic [31:0]           buf_d;
   logic [ADDR_WIDTH-1:0] cap_off;
   logic [ADDR_WIDTH-1:0] iss_off;
   logic [ADDR_WIDTH-1:0] nxt_off;

   mem_ctrl_arb u_arb (
      .clk_i     (clk_in),
      .rst_i     (rst_in),
      .en_i      (grant_en),
      .if_req_i  (if_req),
      .ls_req_i  (ls_req),
      .gnt_vld_o (gnt_vld),
      .gnt_ls_o  (gnt_ls)
   );

   always_comb begin
      // Grants are taken in IDLE and in the DONE cycle, never while the
      // host owns the bus or a flush is in progress.
      grant_en = rdy_in & ~clear_in & ((state_q == ST_IDLE) | (state_q == ST_DONE));
      gnt_addr = gnt_ls ? ls_addr : if_addr;

      // The region check uses the byte actually on the bus, so a write
      // that straddles into the I/O region is throttled byte by byte.
      cur_io  = (mem_a_q[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == IO_TAG);
      wr_fire = rdy_in & ~(cur_io & io_buffer_full);

      // A returning byte only counts when the bus was ours both when it
      // was addressed (din_vld_q) and now (rdy_in).
      rd_cap  = din_vld_q & rdy_in;
      cap_d   = cap_q + {2'b00, rd_cap};
      nxt_idx = iss_q + 3'd1;

      buf_d = buf_q;
      if (rd_cap) begin
         buf_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
      end

      cap_off = ADDR_WIDTH'(cap_q);
      iss_off = ADDR_WIDTH'(iss_q);
      nxt_off = ADDR_WIDTH'(nxt_idx);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         mem_a_q    <= '0;
         n_q        <= 3'd0;
         iss_q      <= 3'd0;
         cap_q      <= 3'd0;
         bus_act_q  <= 1'b0;
         din_vld_q  <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_dout_q <= 8'h00;
         wdata_q    <= 32'h0;
         buf_q      <= 32'h0;
         if_done_q  <= 1'b0;
         ls_done_q  <= 1'b0;
         if_data_q  <= 32'h0;
         ls_rdata_q <= 32'h0;
      end else begin
         if_done_q <= 1'b0;
         ls_done_q <= 1'b0;

         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (grant_en && gnt_vld) begin
                  base_q    <= gnt_addr;
                  mem_a_q   <= gnt_addr;
                  cap_q     <= 3'd0;
                  buf_q     <= 32'h0;
                  din_vld_q <= 1'b0;
                  if (gnt_ls) begin
                     n_q     <= byte_count(ls_size);
                     wdata_q <= ls_wdata;
                     if (ls_we) begin
                        state_q    <= ST_LS_WR;
                        mem_wr_q   <= 1'b1;
                        mem_dout_q <= ls_wdata[7:0];
                        iss_q      <= 3'd0;
                        bus_act_q  <= 1'b0;
                     end else begin
                        state_q   <= ST_LS_RD;
                        iss_q     <= 3'd1;
                        bus_act_q <= 1'b1;
                     end
                  end else begin
                     n_q       <= 3'd4;
                     state_q   <= ST_IF_RD;
                     iss_q     <= 3'd1;
                     bus_act_q <= 1'b1;
                  end
               end else if (rdy_in) begin
                  state_q <= ST_IDLE;
               end
            end

            ST_IF_RD, ST_LS_RD: begin
               if (!rdy_in) begin
                  // Everything not yet captured is lost; keep re-presenting
                  // the first missing byte so it goes out as soon as the
                  // bus comes back.
                  din_vld_q <= 1'b0;
                  bus_act_q <= 1'b1;
                  mem_a_q   <= base_q + cap_off;
                  iss_q     <= cap_q + 3'd1;
               end else if (clear_in) begin
                  state_q   <= ST_IDLE;
                  bus_act_q <= 1'b0;
                  din_vld_q <= 1'b0;
               end else begin
                  buf_q     <= buf_d;
                  cap_q     <= cap_d;
                  din_vld_q <= bus_act_q;
                  if (iss_q < n_q) begin
                     mem_a_q   <= base_q + iss_off;
                     iss_q     <= nxt_idx;
                     bus_act_q <= 1'b1;
                  end else begin
                     bus_act_q <= 1'b0;
                  end
                  if (cap_d == n_q) begin
                     state_q   <= ST_DONE;
                     bus_act_q <= 1'b0;
                     din_vld_q <= 1'b0;
                     if (state_q == ST_IF_RD) begin
                        if_done_q <= 1'b1;
                        if_data_q <= buf_d;
                     end else begin
                        ls_done_q  <= 1'b1;
                        ls_rdata_q <= buf_d;
                     end
                  end
               end
            end

            ST_LS_WR: begin
               // Stores ignore clear_in: a store that has started must land.
               if (wr_fire) begin
                  if (nxt_idx == n_q) begin
                     state_q   <= ST_DONE;
                     mem_wr_q  <= 1'b0;
                     ls_done_q <= 1'b1;
                  end else begin
                     iss_q      <= nxt_idx;
                     mem_a_q    <= base_q + nxt_off;
                     mem_dout_q <= wdata_q[{nxt_idx[1:0], 3'b000} +: 8];
                  end
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // The strobe is masked in the same cycle the host takes the bus or the
   // I/O buffer fills, so no write escapes while either condition holds.
   assign mem_wr   = mem_wr_q & wr_fire;
   assign mem_a    = mem_a_q;
   assign mem_dout = mem_dout_q;
   assign if_done  = if_done_q;
   assign if_data  = if_data_q;
   assign ls_done  = ls_done_q;
   assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - table-driven and sequence checks for mem_ctrl
module tb_mem_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        clear_in;
   logic        io_buffer_full;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_data;
   logic        ls_req;
   logic        ls_we;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;

   always #5 clk_in = ~clk_in;

   mem_ctrl dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .clear_in       (clear_in),
      .io_buffer_full (io_buffer_full),
      .if_req         (if_req),
      .if_addr        (if_addr),
      .if_done        (if_done),
      .if_data        (if_data),
      .ls_req         (ls_req),
      .ls_we          (ls_we),
      .ls_size        (ls_size),
      .ls_addr        (ls_addr),
      .ls_wdata       (ls_wdata),
      .ls_done        (ls_done),
      .ls_rdata       (ls_rdata),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr)
   );

   // Byte memory: read data appears the cycle after its address. While the
   // host owns the bus the read lane carries junk.
   logic [7:0] mem [logic [31:0]];
   logic [7:0] din_q = 8'h00;
   int         io_wr_cnt = 0;

   always @(posedge clk_in) begin
      if (mem_wr) begin
         mem[mem_a] = mem_dout;
         if (mem_a == 32'h0003_0000) io_wr_cnt++;
      end
      din_q <= mem.exists(mem_a) ? mem[mem_a] : 8'h00;
   end
   assign mem_din = rdy_in ? din_q : 8'hEE;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   typedef struct {
      logic        is_ls;
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      int          n;
      int          exp_cyc;
   } vec_t;

   vec_t vt[12];

   // Called at the start of cycle 0; returns at the start of the cycle
   // following the one after the done pulse.
   task automatic run_vec(input int idx, input vec_t v);
      int dc;
      dc = -1;
      if (v.is_ls) begin
         ls_req = 1'b1; ls_we = v.we; ls_size = v.size; ls_addr = v.addr; ls_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_in);
         if (c >= 1 && c <= v.n) begin
            check($sformatf("v%0d_c%0d_mem_a", idx, c), mem_a, v.addr + c - 1);
            check($sformatf("v%0d_c%0d_mem_wr", idx, c), {31'b0, mem_wr}, {31'b0, v.we});
            if (v.we)
               check($sformatf("v%0d_c%0d_mem_dout", idx, c), {24'b0, mem_dout}, (v.wdata >> (8 * (c - 1))) & 32'hFF);
         end
         if (v.is_ls ? ls_done : if_done) begin
            dc = c;
            if_req = 1'b0;
            ls_req = 1'b0;
            if (v.we) begin
               check($sformatf("v%0d_wr_idle", idx), {31'b0, mem_wr}, 32'h0);
            end else begin
               check($sformatf("v%0d_data", idx), v.is_ls ? ls_rdata : if_data, v.exp_data);
               check($sformatf("v%0d_no_extra_rd", idx), mem_a, v.addr + v.n - 1);
            end
            break;
         end
         cyc();
      end
      if (dc < 0) begin
         if_req = 1'b0;
         ls_req = 1'b0;
      end
      check($sformatf("v%0d_done_cycle", idx), dc, v.exp_cyc);
      cyc();
      @(negedge clk_in);
      check($sformatf("v%0d_done_pulse", idx), {31'b0, (v.is_ls ? ls_done : if_done)}, 32'h0);
      cyc();
   endtask

   initial begin
      int dc;
      int k;
      logic seen;
      int base_cnt;
      logic [31:0] alt_cyc [4];
      logic        alt_ls  [4];

      rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
      if_req = 1'b0; if_addr = 32'h0;
      ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'h0; ls_wdata = 32'h0;

      mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h00; mem[32'h103] = 8'h00;
      mem[32'h3002] = 8'h77; mem[32'h3003] = 8'h66;
      mem[32'h30004] = 8'h5A;

      //              is_ls we  size   addr          wdata         exp_data      n  cyc
      vt[0]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,        32'h0000_0513, 4, 6};
      vt[1]  = '{1'b1, 1'b1, 2'b10, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0,        4, 5};
      vt[2]  = '{1'b1, 1'b0, 2'b10, 32'h0000_2000, 32'h0,        32'hDEAD_BEEF, 4, 6};
      vt[3]  = '{1'b1, 1'b0, 2'b01, 32'h0000_2002, 32'h0,        32'h0000_DEAD, 2, 4};
      vt[4]  = '{1'b1, 1'b0, 2'b00, 32'h0000_2001, 32'h0,        32'h0000_00BE, 1, 3};
      vt[5]  = '{1'b1, 1'b1, 2'b01, 32'h0000_3000, 32'hAAAA_1234, 32'h0,        2, 3};
      vt[6]  = '{1'b1, 1'b0, 2'b11, 32'h0000_3000, 32'h0,        32'h6677_1234, 4, 6};
      vt[7]  = '{1'b1, 1'b1, 2'b11, 32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0,        4, 5};
      vt[8]  = '{1'b0, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,        32'hCAFE_F00D, 4, 6};
      vt[9]  = '{1'b1, 1'b0, 2'b00, 32'h0003_0004, 32'h0,        32'h0000_005A, 1, 3};
      vt[10] = '{1'b1, 1'b1, 2'b00, 32'h0000_0010, 32'h1234_5678, 32'h0,        1, 2};
      vt[11] = '{1'b1, 1'b0, 2'b01, 32'h0000_000F, 32'h0,        32'h0000_7800, 2, 4};

      cyc();
      cyc();
      @(negedge clk_in);
      check("rst_mem_wr",   {31'b0, mem_wr}, 32'h0);
      check("rst_mem_a",    mem_a, 32'h0);
      check("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
      check("rst_if_done",  {31'b0, if_done}, 32'h0);
      check("rst_ls_done",  {31'b0, ls_done}, 32'h0);
      check("rst_if_data",  if_data, 32'h0);
      check("rst_ls_rdata", ls_rdata, 32'h0);
      cyc();
      rst_in = 1'b0;

      for (int i = 0; i < 12; i++) run_vec(i, vt[i]);

      // I/O byte store held off by a full output buffer in cycles 1..3
      base_cnt = io_wr_cnt;
      ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h0003_0000; ls_wdata = 32'h0000_0041;
      cyc();
      io_buffer_full = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk_in);
         check($sformatf("io_c%0d_held", c), {30'b0, mem_wr, ls_done}, 32'h0);
         cyc();
      end
      io_buffer_full = 1'b0;
      @(negedge clk_in);
      check("io_c4_mem_wr",   {31'b0, mem_wr}, 32'h1);
      check("io_c4_mem_a",    mem_a, 32'h0003_0000);
      check("io_c4_mem_dout", {24'b0, mem_dout}, 32'h41);
      cyc();
      @(negedge clk_in);
      check("io_c5_ls_done", {31'b0, ls_done}, 32'h1);
      check("io_c5_mem_wr",  {31'b0, mem_wr}, 32'h0);
      ls_req = 1'b0;
      cyc();
      cyc();
      check("io_write_count", io_wr_cnt - base_cnt, 32'd1);

      // Fetch with the bus lent to the host in cycles 3 and 4
      dc = -1;
      if_req = 1'b1; if_addr = 32'h0000_0100;
      for (int c = 0; c < 30; c++) begin
         if (c == 3) rdy_in = 1'b0;
         if (c == 5) rdy_in = 1'b1;
         @(negedge clk_in);
         if (c == 5) check("rdy_reissue_addr", mem_a, 32'h0000_0101);
         if (if_done) begin
            dc = c;
            if_req = 1'b0;
            check("rdy_if_data", if_data, 32'h0000_0513);
            break;
         end
         cyc();
      end
      if_req = 1'b0;
      rdy_in = 1'b1;
      check("rdy_done_cycle", dc, 32'd9);
      cyc();
      cyc();

      // Flush in cycle 3 of a fetch, then a byte load in the next IDLE cycle
      dc = -1;
      seen = 1'b0;
      if_req = 1'b1; if_addr = 32'h0000_0100;
      for (int c = 0; c < 30; c++) begin
         if (c == 3) clear_in = 1'b1;
         if (c == 4) begin
            clear_in = 1'b0; if_req = 1'b0;
            ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'h0000_2001;
         end
         @(negedge clk_in);
         if (if_done) seen = 1'b1;
         if (c == 5) check("clr_ls_addr", mem_a, 32'h0000_2001);
         if (ls_done) begin
            dc = c;
            ls_req = 1'b0;
            check("clr_ls_data", ls_rdata, 32'h0000_00BE);
            break;
         end
         cyc();
      end
      ls_req = 1'b0;
      clear_in = 1'b0;
      check("clr_no_if_done", {31'b0, seen}, 32'h0);
      check("clr_ls_done_cycle", dc, 32'd7);
      cyc();
      cyc();

      // Reset in the middle of a word store
      seen = 1'b0;
      ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h0000_4000; ls_wdata = 32'h1122_3344;
      for (int c = 0; c < 10; c++) begin
         if (c == 2) rst_in = 1'b1;
         if (c == 3) begin
            rst_in = 1'b0;
            ls_req = 1'b0;
         end
         @(negedge clk_in);
         if (ls_done) seen = 1'b1;
         if (c == 3) check("mrst_mem_wr", {31'b0, mem_wr}, 32'h0);
         cyc();
      end
      check("mrst_no_done", {31'b0, seen}, 32'h0);
      check("mrst_byte2_unwritten", mem.exists(32'h0000_4002), 32'h0);

      // Both requesters held continuously: LS, IF, LS, IF every 6 cycles
      k = 0;
      if_req = 1'b1; if_addr = 32'h0000_0100;
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h0000_2000;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk_in);
         if (if_done && ls_done) check("alt_both_done", 32'h1, 32'h0);
         if (if_done || ls_done) begin
            alt_cyc[k] = c;
            alt_ls[k]  = ls_done;
            check($sformatf("alt%0d_data", k), ls_done ? ls_rdata : if_data,
                  ls_done ? 32'hDEAD_BEEF : 32'h0000_0513);
            k++;
            if (k == 4) begin
               if_req = 1'b0;
               ls_req = 1'b0;
               break;
            end
         end
         cyc();
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      check("alt_count", k, 32'd4);
      for (int i = 0; i < k; i++) begin
         check($sformatf("alt%0d_winner_ls", i), {31'b0, alt_ls[i]}, (i % 2 == 0) ? 32'h1 : 32'h0);
         check($sformatf("alt%0d_cycle", i), alt_cyc[i], 6 * (i + 1));
      end
      cyc();
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
